uart_rx: RTL

- Serial receiver: the downstream partner of the UART transmitter. Consumes the transmitter's serial line and recovers parallel words.
- Frame format: 1 start bit (0), WORD_SIZE data bits LSB-first, 1 stop bit (1).
- Oversamples the line using a sample-rate enable, samples each bit at its midpoint, and holds the received word for the host with a ready/read handshake plus overrun and framing error flags.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_sync.sv | 19 +
 rtl/uart_rx.sv | 126 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default frame geometry
// and the line levels of the start/stop bits (common to transmitter and receiver).
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STARTING,
    RECEIVING
  } rx_state_e;

  localparam int unsigned UART_WORD_SIZE  = 8;
  localparam int unsigned UART_OVERSAMPLE = 8;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle
// (high) level so no false start is seen coming out of reset.
module uart_rx_sync (
  input  logic CLOCK,
  input  logic RESET,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q;

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) sync_q <= '1;
    else        sync_q <= {sync_q[0], d};
  end

  assign q = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start detection, mid-bit sampling of LSB-first
// data and stop bit, with a ready/read handshake and overrun/framing flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned WORD_SIZE  = UART_WORD_SIZE,
  parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  input  logic                 SAMPLE_TICK,
  input  logic                 SERIAL_IN,
  input  logic                 READ_NOT_READY_IN,
  output logic [WORD_SIZE-1:0] RCV_DATAREG,
  output logic                 READ_NOT_READY_OUT,
  output logic                 ERROR1,
  output logic                 ERROR2
);

  localparam int unsigned SC_W = $clog2(OVERSAMPLE);
  localparam int unsigned BC_W = $clog2(WORD_SIZE + 1);
  localparam logic [SC_W-1:0] SC_HALF = SC_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(OVERSAMPLE - 1);
  localparam logic [BC_W-1:0] BC_STOP = BC_W'(WORD_SIZE);

  logic rx_s;

  rx_state_e            state_q, state_d;
  logic [SC_W-1:0]      sample_cnt_q, sample_cnt_d;
  logic [BC_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [WORD_SIZE-1:0] shift_q, shift_d;
  logic [WORD_SIZE-1:0] data_q, data_d;
  logic                 ready_q, ready_d;
  logic                 err1_q, err1_d;
  logic                 err2_q, err2_d;

  uart_rx_sync u_sync (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .d     (SERIAL_IN),
    .q     (rx_s)
  );

  always_comb begin
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    data_d       = data_q;
    ready_d      = ready_q;
    err1_d       = err1_q;
    err2_d       = err2_q;

    // A host read clears ready; a frame completing in the same cycle overrides it below.
    if (READ_NOT_READY_IN) ready_d = 1'b0;

    if (SAMPLE_TICK) begin
      unique case (state_q)
        IDLE: begin
          if (rx_s == START_BIT) begin
            state_d      = STARTING;
            sample_cnt_d = '0;
          end
        end
        STARTING: begin
          if (rx_s != START_BIT) begin
            state_d = IDLE;
          end else if (sample_cnt_q == SC_HALF) begin
            state_d      = RECEIVING;
            sample_cnt_d = '0;
            bit_cnt_d    = '0;
          end else begin
            sample_cnt_d = sample_cnt_q + SC_W'(1);
          end
        end
        RECEIVING: begin
          if (sample_cnt_q != SC_LAST) begin
            sample_cnt_d = sample_cnt_q + SC_W'(1);
          end else begin
            sample_cnt_d = '0;
            if (bit_cnt_q != BC_STOP) begin
              shift_d              = shift_q >> 1;
              shift_d[WORD_SIZE-1] = rx_s;
              bit_cnt_d            = bit_cnt_q + BC_W'(1);
            end else begin
              state_d = IDLE;
              data_d  = shift_q;
              ready_d = 1'b1;
              err2_d  = (rx_s != STOP_BIT);
              err1_d  = ready_q & ~READ_NOT_READY_IN;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q      <= IDLE;
      sample_cnt_q <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      ready_q      <= 1'b0;
      err1_q       <= 1'b0;
      err2_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sample_cnt_q <= sample_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      ready_q      <= ready_d;
      err1_q       <= err1_d;
      err2_q       <= err2_d;
    end
  end

  assign RCV_DATAREG        = data_q;
  assign READ_NOT_READY_OUT = ready_q;
  assign ERROR1             = err1_q;
  assign ERROR2             = err2_q;

endmodule
